// File: rtl/secret_stim_gen_pkg.sv
// secret_stim_pkg: shared FSM states, default LFSR constants and the signature fold
package secret_stim_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stim_state_e;
  localparam logic [31:0] STIM_DEFAULT_SEED = 32'h0000_0001;
  localparam logic [31:0] STIM_DEFAULT_TAPS = 32'h8020_0003;
  localparam int STIM_MAX_WIDTH = 64;
  // rotate sig left by one within w bits, then xor in x; operands are zero-extended
  function automatic logic [STIM_MAX_WIDTH-1:0] sig_fold(input logic [STIM_MAX_WIDTH-1:0] sig, x, input int w);
    logic [STIM_MAX_WIDTH-1:0] m;
    m = {STIM_MAX_WIDTH{1'b1}} >> (STIM_MAX_WIDTH - w);
    return (((sig << 1) | (sig >> (w - 1))) & m) ^ x;
  endfunction
endpackage

// File: rtl/secret_stim_gen_if.sv
// secret_stim_if: operand/result bus between the stimulus source and the secret block
interface secret_stim_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] a, b, x;
  modport master (output a, b, input x);
  modport slave (input a, b, output x);
endinterface

// File: rtl/secret_stim_gen_lfsr.sv
// secret_lfsr: Galois LFSR with seed reload and single-step advance
module secret_lfsr import secret_stim_pkg::*; #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(STIM_DEFAULT_SEED),
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(STIM_DEFAULT_TAPS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic adv,
  output logic [WIDTH-1:0] state
);
  logic [WIDTH-1:0] base;
  assign base = load ? SEED : state;
  // load and adv together yield the step after SEED, so a restart launches SEED this edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= SEED;
    else if (load || adv) state <= adv ? (base >> 1) ^ (base[0] ? TAPS : '0) : base;
endmodule

// File: rtl/secret_stim_gen.sv
// secret_stim_gen: LFSR operand source for verilated_secret with a rotate-xor result signature
module secret_stim_gen import secret_stim_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int NUM_VECTORS = 16,
  parameter int LATENCY = 2,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(STIM_DEFAULT_SEED),
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(STIM_DEFAULT_TAPS),
  localparam int VW = $clog2(NUM_VECTORS + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  secret_stim_if.master bus,
  output logic busy,
  output logic done,
  output logic [VW-1:0] vec_count,
  output logic [WIDTH-1:0] signature
);
  stim_state_e state, next;
  logic go, launch, sample, last;
  logic [VW-1:0] lcnt;
  logic [LATENCY-1:0] vs;
  logic [WIDTH-1:0] lfsr_q, src, fold;
  assign go = (state == IDLE || state == DONE) && start;
  assign launch = go || (state == RUN && lcnt != VW'(NUM_VECTORS));
  assign sample = vs[LATENCY-1];
  assign last = sample && vec_count == VW'(NUM_VECTORS - 1);
  assign src = go ? SEED : lfsr_q;
  assign fold = WIDTH'(sig_fold(STIM_MAX_WIDTH'(signature), STIM_MAX_WIDTH'(bus.x), WIDTH));
  secret_lfsr #(.WIDTH(WIDTH), .SEED(SEED), .TAPS(TAPS)) u_lfsr (
    .clk(clk), .rst_n(rst_n), .load(go), .adv(launch), .state(lfsr_q)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // final sample ends the run from RUN (LATENCY=1) or DRAIN; running out of vectors enters DRAIN
  always_comb begin
    next = state;
    if (go) next = RUN;
    else if (last) next = DONE;
    else if (state == RUN && !launch) next = DRAIN;
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
  end
  // operand launch, in-flight valid pipe, result counter and signature
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.a <= '0;
      bus.b <= '0;
      vs <= '0;
      lcnt <= '0;
      vec_count <= '0;
      signature <= '0;
    end else begin
      bus.a <= launch ? src : '0;
      bus.b <= launch ? {src[WIDTH/2-1:0], src[WIDTH-1:WIDTH/2]} : '0;
      vs <= LATENCY'({vs, launch});
      lcnt <= go ? VW'(1) : lcnt + VW'(launch);
      vec_count <= go ? '0 : vec_count + VW'(sample);
      signature <= go ? '0 : sample ? fold : signature;
    end
endmodule
